dmem_responder: RTL and testbench

Data-memory responder serving the core's data-memory master port, the slave end of the core data bus. Accepts one read or write request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs the access on an internal word-organised RAM with byte enables, and returns a single-cycle response. It replaces the zero-latency behavioural RAM so the core can be exercised against realistic memory latency.

---
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated, byte-enabled data RAM slave for the core data bus.
// Define DMEM_ERR_EN to reject misaligned and out-of-range accesses with rsp_err.
module dmem_responder #(
    parameter int ADDRWIDTH   = 32,
    parameter int BUSWIDTH    = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  cpu_rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wren,
    input  logic [ADDRWIDTH-1:0]  req_addr,
    input  logic [BUSWIDTH-1:0]   req_wdata,
    input  logic [BUSWIDTH/8-1:0] req_be,
    output logic                  rsp_valid,
    output logic [BUSWIDTH-1:0]   rsp_rdata,
    output logic                  rsp_err
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int NB = BUSWIDTH / 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wren_q, wren_d;
    logic [ADDRWIDTH-1:0]  addr_q, addr_d;
    logic [BUSWIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]         be_q, be_d;
    logic [BUSWIDTH-1:0]   rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept, access, err;
    logic                  a_wren;
    logic [ADDRWIDTH-1:0]  a_addr;
    logic [BUSWIDTH-1:0]   a_wdata;
    logic [NB-1:0]         a_be;
    logic [IW-1:0]         idx;
    logic [BUSWIDTH-1:0]   mem [DEPTH_WORDS];

    always_comb begin
        accept  = req_valid && (state_q == IDLE);
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
            WAIT:    state_d = (cnt_q == 4'd1) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
        cnt_d   = accept ? 4'(WAIT_CYCLES) : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
        wren_d  = accept ? req_wren  : wren_q;
        addr_d  = accept ? req_addr  : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;
        be_d    = accept ? req_be    : be_q;
        // With zero wait states the access happens on the accept edge itself
        a_wren  = (state_q == IDLE) ? req_wren  : wren_q;
        a_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        a_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        a_be    = (state_q == IDLE) ? req_be    : be_q;
        access  = cpu_rstn && (state_d == RESP) && (state_q != RESP);
        idx     = a_addr[2 +: IW];
`ifdef DMEM_ERR_EN
        err     = (a_addr[1:0] != 2'b00) || (|a_addr[ADDRWIDTH-1:IW+2]);
`else
        err     = 1'b0;
`endif
        rdata_d = access ? ((a_wren || err) ? '0 : mem[idx]) : rdata_q;
        err_d   = access ? err : err_q;
    end

`ifndef DMEM_ERR_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_addr[1:0], a_addr[ADDRWIDTH-1:IW+2]};
`endif

    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (access && a_wren && !err)
            for (int i = 0; i < NB; i++)
                if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (0, 1 and 3 wait states) checked against a word-array memory model.
module tb_dmem_responder;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        cpu_rstn [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wren [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err [3];

    int          wc [3] = '{0, 1, 3};
    logic [31:0] mdl [3][DEPTH];
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .ADDRWIDTH(32), .BUSWIDTH(32), .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 1 : 3)
        ) dut (
            .clk(clk), .cpu_rstn(cpu_rstn[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_wren(req_wren[g]), .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]), .req_be(req_be[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int k, input logic wr, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] be,
                                  output logic e, output logic [31:0] rd);
        int w;
        w  = int'((a / 4) % DEPTH);
`ifdef DMEM_ERR_EN
        e  = (a % 4 != 0) || (a / 4 >= DEPTH);
`else
        e  = 1'b0;
`endif
        rd = 32'h0;
        if (!e) begin
            if (!wr) rd = mdl[k][w];
            else for (int b = 0; b < 4; b++)
                if (be[b]) mdl[k][w][8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    task automatic xact(input int k, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        logic        e;
        logic [31:0] rd;
        int          n;
        model(k, wr, a, wd, be, e, rd);
        @(negedge clk);
        n = 0;
        while (!req_ready[k] && n < 40) begin @(negedge clk); n++; end
        chk($sformatf("ready_before_req%0d", k), 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; req_wren[k] = wr; req_addr[k] = a; req_wdata[k] = wd; req_be[k] = be;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            req_valid[k] = 1'b0;
            req_wren[k]  = 1'($urandom);
            req_addr[k]  = $urandom;
            req_wdata[k] = $urandom;
            req_be[k]    = 4'($urandom);
        end while (!rsp_valid[k] && n < 40);
        chk($sformatf("latency%0d", k), 32'(n), 32'(wc[k] + 1));
        chk($sformatf("err%0d_%h", k, a), 32'(rsp_err[k]), 32'(e));
        chk($sformatf("rdata%0d_%h", k, a), rsp_rdata[k], rd);
        @(negedge clk);
        chk($sformatf("pulse%0d", k), 32'(rsp_valid[k]), 32'd0);
    endtask

    initial begin
        int j;
        for (int k = 0; k < 3; k++) begin
            cpu_rstn[k] = 1'b0; req_valid[k] = 1'b0; req_wren[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) cpu_rstn[k] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("rst_ready", 32'(req_ready[k]), 32'd1);
                chk("rst_valid", 32'(rsp_valid[k]), 32'd0);
                chk("rst_rdata", rsp_rdata[k], 32'd0);
                chk("rst_err", 32'(rsp_err[k]), 32'd0);
            end
        end
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 16; w++) xact(k, 1'b1, 32'(w * 4), $urandom, 4'hF);

        xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xact(1, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("deadbeef_model", mdl[1][4], 32'hDEADBEEF);

        xact(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
        xact(1, 1'b1, 32'h20, 32'h11223344, 4'h5);
        xact(1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("merge_model", mdl[1][8], 32'hAA22CC44);

        @(negedge clk);
        req_valid[0] = 1'b1; req_wren[0] = 1'b0; req_addr[0] = 32'h0;
        j = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_valid_c%0d", c), 32'(rsp_valid[0]), 32'(c % 2));
            chk($sformatf("b2b_ready_c%0d", c), 32'(req_ready[0]), 32'(1 - c % 2));
            if (rsp_valid[0]) begin
                chk($sformatf("b2b_rdata%0d", j), rsp_rdata[0], mdl[0][j]);
                j++;
                req_addr[0] = 32'(j * 4);
            end
            if (c == 8) req_valid[0] = 1'b0;
        end

        xact(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF);
        xact(1, 1'b0, 32'h13, 32'h0, 4'h0);
        xact(1, 1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF);
        xact(1, 1'b0, 32'h0, 32'h0, 4'h0);
`ifdef DMEM_ERR_EN
        chk("oor_word0", mdl[1][0], 32'h0BADF00D);
`else
        chk("wrap_word0", mdl[1][0], 32'hCAFEF00D);
`endif

        @(negedge clk);
        req_valid[2] = 1'b1; req_wren[2] = 1'b1; req_addr[2] = 32'h14;
        req_wdata[2] = 32'h55AA55AA; req_be[2] = 4'hF;
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("abort_busy", 32'(req_ready[2]), 32'd0);
        cpu_rstn[2] = 1'b0;
        #1;
        chk("abort_idle", 32'(req_ready[2]), 32'd1);
        chk("abort_rdata", rsp_rdata[2], 32'd0);
        @(negedge clk);
        cpu_rstn[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_norsp", 32'(rsp_valid[2]), 32'd0);
        end
        xact(2, 1'b0, 32'h14, 32'h0, 4'h0);

        for (int i = 0; i < 40; i++)
            xact(int'($urandom_range(0, 2)), 1'($urandom), 32'($urandom_range(0, 15) * 4),
                 $urandom, 4'($urandom));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
